// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//   Turns structured RV32I instruction commands into 32-bit instruction words
//   for the debug/test-injection path into the fetch stream. Illegal field
//   combinations are consumed without emitting a word: they pulse err and
//   bump a saturating counter. Both sides use valid/ready handshakes, and the
//   output is a single register, so throughput is one word per cycle.
//
//   Optional feature macro: INST_ENC_LI_EN
//     defined   : cmd_op 9 (LI) expands to ADDI, or to LUI followed by ADDI
//     undefined : the LI_LO state is omitted and cmd_op 9 is illegal
//
// Parameters
//   ERR_CNT_W   width of the saturating illegal-command counter
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (accepted when both are high)
//   cmd_op              0 OP,1 OPIMM,2 BRANCH,3 AUIPC,4 LUI,5 JALR,6 JAL,
//                       7 LOAD,8 STORE,9 LI
//   cmd_funct3,cmd_alt  funct3 field, funct7=0100000 select
//   cmd_rd/rs1/rs2      register fields
//   cmd_imm             full signed immediate
//   inst_valid/ready    instruction word handshake
//   inst_data,inst_last encoded word, final word of the current command
//   err, err_cnt        illegal-command pulse and saturating count
// -----------------------------------------------------------------------------
module inst_encoder #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           cmd_op,
   input  logic [2:0]           cmd_funct3,
   input  logic                 cmd_alt,
   input  logic [4:0]           cmd_rd,
   input  logic [4:0]           cmd_rs1,
   input  logic [4:0]           cmd_rs2,
   input  logic [31:0]          cmd_imm,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [31:0]          inst_data,
   output logic                 inst_last,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

`ifdef INST_ENC_LI_EN
   typedef enum logic {
      S_IDLE,
      S_LI_LO
   } state_t;

   state_t       r_state;
   logic [31:0]  r_li_lo;
   logic         w_li_two;
   logic [31:0]  w_li_lo;
`endif

   logic                 r_vld;
   logic [31:0]          r_data;
   logic                 r_last;
   logic                 r_err;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic                 w_idle;
   logic                 w_slot_free;
   logic                 w_cmd_ready;
   logic                 w_fire;
   logic signed [31:0]   w_imm;
   logic                 w_i_ok;
   logic                 w_b_ok;
   logic                 w_j_ok;
   logic                 w_alt_ok;
   logic                 w_is_shift;
   logic [6:0]           w_alt7;
   logic [31:0]          w_word;
   logic                 w_illegal;

`ifdef INST_ENC_LI_EN
   assign w_idle = (r_state == S_IDLE);
`else
   assign w_idle = 1'b1;
`endif

   // The output register can take a new word when empty or being drained.
   assign w_slot_free = !r_vld || inst_ready;
   assign w_cmd_ready = w_idle && w_slot_free;
   assign w_fire      = cmd_valid && w_cmd_ready;

   assign w_imm  = cmd_imm;
   assign w_i_ok = (w_imm >= -32'sd2048)    && (w_imm <= 32'sd2047);
   assign w_b_ok = (w_imm >= -32'sd4096)    && (w_imm <= 32'sd4094);
   assign w_j_ok = (w_imm >= -32'sd1048576) && (w_imm <= 32'sd1048575);

   // cmd_alt is only meaningful for ADD/SUB, SRL/SRA and SRLI/SRAI.
   assign w_alt_ok = ((cmd_op == 4'd0) && ((cmd_funct3 == 3'b000) || (cmd_funct3 == 3'b101))) ||
                     ((cmd_op == 4'd1) && (cmd_funct3 == 3'b101));
   assign w_is_shift = (cmd_funct3 == 3'b001) || (cmd_funct3 == 3'b101);
   assign w_alt7     = cmd_alt ? 7'b0100000 : 7'b0000000;

   always_comb begin
      w_word    = '0;
      w_illegal = 1'b0;
`ifdef INST_ENC_LI_EN
      w_li_two  = 1'b0;
      w_li_lo   = {cmd_imm[11:0], cmd_rd, 3'b000, cmd_rd, OPC_OPIMM};
`endif
      if (cmd_alt && !w_alt_ok)
         w_illegal = 1'b1;

      case (cmd_op)
         4'd0: begin
            w_word = {w_alt7, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, OPC_OP};
         end
         4'd1: begin
            // Shift-immediates carry funct7 in the upper immediate bits.
            if (w_is_shift)
               w_word = {w_alt7, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, OPC_OPIMM};
            else
               w_word = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OPC_OPIMM};
            if (!w_i_ok)
               w_illegal = 1'b1;
         end
         4'd2: begin
            w_word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                      cmd_imm[4:1], cmd_imm[11], OPC_BRANCH};
            if ((cmd_funct3 == 3'b010) || (cmd_funct3 == 3'b011) || cmd_imm[0] || !w_b_ok)
               w_illegal = 1'b1;
         end
         4'd3: begin
            w_word = {cmd_imm[31:12], cmd_rd, OPC_AUIPC};
         end
         4'd4: begin
            w_word = {cmd_imm[31:12], cmd_rd, OPC_LUI};
         end
         4'd5: begin
            w_word = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OPC_JALR};
            if ((cmd_funct3 != 3'b000) || !w_i_ok)
               w_illegal = 1'b1;
         end
         4'd6: begin
            w_word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, OPC_JAL};
            if (cmd_imm[0] || !w_j_ok)
               w_illegal = 1'b1;
         end
         4'd7: begin
            w_word = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OPC_LOAD};
            if ((cmd_funct3 == 3'b011) || (cmd_funct3 == 3'b110) ||
                (cmd_funct3 == 3'b111) || !w_i_ok)
               w_illegal = 1'b1;
         end
         4'd8: begin
            w_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], OPC_STORE};
            if (cmd_funct3[2] || (cmd_funct3[1:0] == 2'b11) || !w_i_ok)
               w_illegal = 1'b1;
         end
`ifdef INST_ENC_LI_EN
         4'd9: begin
            if (w_i_ok) begin
               w_word = {cmd_imm[11:0], 5'd0, 3'b000, cmd_rd, OPC_OPIMM};
            end else begin
               // ADDI sign-extends its 12 bits, so round the upper part up
               // when bit 11 is set.
               w_li_two = 1'b1;
               w_word   = {cmd_imm[31:12] + {19'd0, cmd_imm[11]}, cmd_rd, OPC_LUI};
            end
         end
`endif
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld     <= 1'b0;
         r_data    <= '0;
         r_last    <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
`ifdef INST_ENC_LI_EN
         r_state   <= S_IDLE;
         r_li_lo   <= '0;
`endif
      end else begin
         r_err <= 1'b0;
         if (w_fire) begin
            if (w_illegal) begin
               r_vld <= 1'b0;
               r_err <= 1'b1;
               if (r_err_cnt != {ERR_CNT_W{1'b1}})
                  r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end else begin
               r_vld  <= 1'b1;
               r_data <= w_word;
               r_last <= 1'b1;
`ifdef INST_ENC_LI_EN
               if (w_li_two) begin
                  r_last  <= 1'b0;
                  r_li_lo <= w_li_lo;
                  r_state <= S_LI_LO;
               end
`endif
            end
         end
`ifdef INST_ENC_LI_EN
         else if ((r_state == S_LI_LO) && w_slot_free) begin
            // The ADDI always follows the LUI, even when imm[11:0] is zero.
            r_vld   <= 1'b1;
            r_data  <= r_li_lo;
            r_last  <= 1'b1;
            r_state <= S_IDLE;
         end
`endif
         else if (w_slot_free) begin
            r_vld <= 1'b0;
         end
      end
   end

   assign cmd_ready  = w_cmd_ready;
   assign inst_valid = r_vld;
   assign inst_data  = r_data;
   assign inst_last  = r_last;
   assign err        = r_err;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
//   Directed and randomized stimulus for inst_encoder. A queue of pending
//   words plus an error counter forms the reference; words are computed from
//   the RV32I field layouts with plain integer arithmetic. A second DUT with
//   ERR_CNT_W=2 sees the same stimulus to cover counter saturation.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [2:0]  cmd_funct3;
   logic        cmd_alt;
   logic [4:0]  cmd_rd;
   logic [4:0]  cmd_rs1;
   logic [4:0]  cmd_rs2;
   logic [31:0] cmd_imm;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic        inst_last;
   logic        err;
   logic [7:0]  err_cnt;

   logic        cmd_ready2;
   logic        inst_valid2;
   logic [31:0] inst_data2;
   logic        inst_last2;
   logic        err2;
   logic [1:0]  err_cnt2;

   always #5 clk = ~clk;

   inst_encoder #(.ERR_CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_funct3(cmd_funct3), .cmd_alt(cmd_alt), .cmd_rd(cmd_rd),
      .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .inst_last(inst_last), .err(err), .err_cnt(err_cnt)
   );

   inst_encoder #(.ERR_CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
      .cmd_op(cmd_op), .cmd_funct3(cmd_funct3), .cmd_alt(cmd_alt), .cmd_rd(cmd_rd),
      .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
      .inst_valid(inst_valid2), .inst_ready(inst_ready), .inst_data(inst_data2),
      .inst_last(inst_last2), .err(err2), .err_cnt(err_cnt2)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [32:0] q[$];          // pending words {last, data}, head is in the slot
   int          m_cnt    = 0;
   bit          m_err    = 1'b0;
   bit          fired    = 1'b0;
   bit          rand_ready = 1'b0;
   bit          dir_arm  = 1'b0;
   string       dir_tag;
   logic [32:0] dir_exp;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic longint i_word(input longint v, input int rs1, input int f3,
                                     input int rd, input int opc);
      return ((v & 'hFFF) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12) |
             (longint'(rd) << 7) | opc;
   endfunction

   function automatic void model(input int op, input int f3, input int alt, input int rd,
                                 input int rs1, input int rs2, input int imm,
                                 output bit ill, output int n,
                                 output logic [32:0] w0, output logic [32:0] w1);
      longint v;
      longint word;
      longint f7;
      longint up;
      bit     i_rng;
      v     = imm;
      ill   = 1'b0;
      n     = 1;
      word  = 0;
      w1    = '0;
      f7    = alt ? 32 : 0;
      i_rng = (v >= -2048) && (v <= 2047);
      if (alt != 0 && !((op == 0 && (f3 == 0 || f3 == 5)) || (op == 1 && f3 == 5)))
         ill = 1'b1;
      case (op)
         0: word = (f7 << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15) |
                   (longint'(f3) << 12) | (longint'(rd) << 7) | 'h33;
         1: begin
            if (f3 == 1 || f3 == 5)
               word = (f7 << 25) | ((v & 31) << 20) | (longint'(rs1) << 15) |
                      (longint'(f3) << 12) | (longint'(rd) << 7) | 'h13;
            else
               word = i_word(v, rs1, f3, rd, 'h13);
            if (!i_rng) ill = 1'b1;
         end
         2: begin
            word = (((v >> 12) & 1) << 31) | (((v >> 5) & 'h3F) << 25) |
                   (longint'(rs2) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12) |
                   (((v >> 1) & 'hF) << 8) | (((v >> 11) & 1) << 7) | 'h63;
            if (f3 == 2 || f3 == 3 || (v % 2) != 0 || v < -4096 || v > 4094) ill = 1'b1;
         end
         3: word = (v & 'hFFFFF000) | (longint'(rd) << 7) | 'h17;
         4: word = (v & 'hFFFFF000) | (longint'(rd) << 7) | 'h37;
         5: begin
            word = i_word(v, rs1, f3, rd, 'h67);
            if (f3 != 0 || !i_rng) ill = 1'b1;
         end
         6: begin
            word = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3FF) << 21) |
                   (((v >> 11) & 1) << 20) | (((v >> 12) & 'hFF) << 12) |
                   (longint'(rd) << 7) | 'h6F;
            if ((v % 2) != 0 || v < -1048576 || v > 1048575) ill = 1'b1;
         end
         7: begin
            word = i_word(v, rs1, f3, rd, 'h03);
            if (f3 == 3 || f3 == 6 || f3 == 7 || !i_rng) ill = 1'b1;
         end
         8: begin
            word = (((v >> 5) & 'h7F) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15) |
                   (longint'(f3) << 12) | ((v & 31) << 7) | 'h23;
            if (f3 > 2 || !i_rng) ill = 1'b1;
         end
`ifdef INST_ENC_LI_EN
         9: begin
            if (i_rng) begin
               word = i_word(v, 0, 0, rd, 'h13);
            end else begin
               n    = 2;
               up   = ((v + 'h800) >> 12) & 'hFFFFF;
               word = (up << 12) | (longint'(rd) << 7) | 'h37;
               w1   = {1'b1, 32'(i_word(v, rd, 0, rd, 'h13))};
            end
         end
`endif
         default: ill = 1'b1;
      endcase
      w0 = {(n == 1), 32'(word)};
   endfunction

   // One clock: compare at the falling edge, then advance the reference.
   task automatic cycle();
      bit          exp_valid;
      bit          exp_rdy;
      bit          ill;
      int          n;
      logic [32:0] w0;
      logic [32:0] w1;
      @(negedge clk);
      exp_valid = (q.size() > 0);
      exp_rdy   = (q.size() == 0) || (q.size() == 1 && inst_ready);
      check("inst_valid", inst_valid, exp_valid);
      if (exp_valid) begin
         check("inst_data", inst_data, q[0][31:0]);
         check("inst_last", inst_last, q[0][32]);
      end
      check("cmd_ready", cmd_ready, exp_rdy);
      check("err", err, m_err);
      check("err_cnt", err_cnt, m_cnt);
      check("err_cnt_w2", err_cnt2, (m_cnt > 3) ? 3 : m_cnt);
      if (dir_arm) begin
         check(dir_tag, {inst_last, inst_data}, dir_exp);
         dir_arm = 1'b0;
      end
      m_err = 1'b0;
      if (exp_valid && inst_ready)
         void'(q.pop_front());
      fired = cmd_valid && exp_rdy;
      if (fired) begin
         model(cmd_op, cmd_funct3, cmd_alt, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, ill, n, w0, w1);
         if (ill) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end else begin
            q.push_back(w0);
            if (n == 2) q.push_back(w1);
         end
      end
      @(posedge clk);
      #1;
      if (rand_ready) inst_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input int op, input int f3, input int alt, input int rd,
                       input int rs1, input int rs2, input int imm, output int ncyc);
      cmd_op     = op[3:0];
      cmd_funct3 = f3[2:0];
      cmd_alt    = alt[0];
      cmd_rd     = rd[4:0];
      cmd_rs1    = rs1[4:0];
      cmd_rs2    = rs2[4:0];
      cmd_imm    = imm;
      cmd_valid  = 1'b1;
      ncyc       = 0;
      do begin
         cycle();
         ncyc++;
      end while (!fired && ncyc < 200);
      if (!fired) check("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
   endtask

   task automatic expect_word(input string tag, input logic [32:0] w);
      dir_arm = 1'b1;
      dir_tag = tag;
      dir_exp = w;
      cycle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nc;
      int op, f3, alt, imm, sel;
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_funct3 = '0;
      cmd_alt    = 1'b0;
      cmd_rd     = '0;
      cmd_rs1    = '0;
      cmd_rs2    = '0;
      cmd_imm    = '0;
      inst_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", inst_valid, 0);
      check("rst_data", inst_data, 0);
      check("rst_last", inst_last, 0);
      check("rst_err", err, 0);
      check("rst_err_cnt", err_cnt, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ADDI x1,x0,5
      send(1, 0, 0, 1, 0, 0, 5, nc);
      expect_word("addi", {1'b1, 32'h00500093});

      // SUB x3,x1,x2 then BEQ x0,x0,+8 back to back
      send(0, 0, 1, 3, 1, 2, 0, nc);
      dir_arm = 1'b1;
      dir_tag = "sub";
      dir_exp = {1'b1, 32'h402081B3};
      send(2, 0, 0, 0, 0, 0, 8, nc);
      check("b2b_accept_cycles", nc, 1);
      expect_word("beq", {1'b1, 32'h00000463});

      // Illegal commands
      send(7, 3, 0, 1, 2, 0, 0, nc);
      send(2, 0, 0, 0, 1, 2, 3, nc);
      send(1, 0, 0, 1, 0, 0, 2048, nc);
      send(12, 0, 0, 1, 0, 0, 0, nc);
      cycle();
      check("err_cnt_after4", err_cnt, 4);
      check("err_cnt_w2_sat", err_cnt2, 3);

`ifdef INST_ENC_LI_EN
      // LI x5,0x12345678 with the sink stalled for 3 cycles
      inst_ready = 1'b0;
      send(9, 0, 0, 5, 0, 0, 32'h12345678, nc);
      repeat (3) expect_word("li_lui_held", {1'b0, 32'h123452B7});
      inst_ready = 1'b1;
      expect_word("li_lui", {1'b0, 32'h123452B7});
      expect_word("li_addi", {1'b1, 32'h67828293});
      send(9, 0, 0, 1, 0, 0, 32'h00000800, nc);
      expect_word("li800_lui", {1'b0, 32'h000010B7});
      expect_word("li800_addi", {1'b1, 32'h80008093});
      send(9, 0, 0, 1, 0, 0, -1, nc);
      expect_word("li_m1", {1'b1, 32'hFFF00093});
      // Reset while the LUI is waiting and the ADDI is pending
      inst_ready = 1'b0;
      send(9, 0, 0, 5, 0, 0, 32'h12345678, nc);
      cycle();
`else
      send(9, 0, 0, 5, 0, 0, 32'h12345678, nc);
      cycle();
      check("li_disabled_cnt", err_cnt, 5);
      inst_ready = 1'b0;
      send(1, 0, 0, 1, 0, 0, 7, nc);
      cycle();
`endif
      #2;
      reset = 1'b1;
      #1;
      check("midrst_valid", inst_valid, 0);
      check("midrst_err_cnt", err_cnt, 0);
      check("midrst_err_cnt_w2", err_cnt2, 0);
      q.delete();
      m_cnt = 0;
      m_err = 1'b0;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      inst_ready = 1'b1;
      send(1, 0, 0, 1, 0, 0, 5, nc);
      expect_word("post_rst_addi", {1'b1, 32'h00500093});
      repeat (3) cycle();

      // Randomized commands with a randomly stalling sink
      rand_ready = 1'b1;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 7) == 0) cycle();
         op  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(10, 15))
                                            : int'($urandom_range(0, 9));
         f3  = $urandom_range(0, 7);
         alt = ($urandom_range(0, 5) == 0);
         sel = $urandom_range(0, 3);
         case (sel)
            0: imm = int'($urandom_range(0, 4095)) - 2048;
            1: imm = int'($urandom_range(0, 10000)) - 5000;
            2: imm = int'($urandom());
            default: imm = int'($urandom_range(0, 2400000)) - 1200000;
         endcase
         if ($urandom_range(0, 3) != 0) imm = imm & ~1;
         send(op, f3, alt, $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), imm, nc);
      end
      for (int k = 0; k < 40 && q.size() > 0; k++) cycle();
      check("drain_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Encodes structured RV32I instruction commands into 32-bit instruction words. It is the encoder counterpart of the core's opcode/funct decode.
Used by the debug/test-injection path to feed instruction words into the fetch stream. Also expands the LI pseudo-op into LUI+ADDI, rejects illegal field combinations, and applies valid/ready backpressure on both sides.

Parameters:
ERR_CNT_W, 8, width of saturating illegal-command counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  4  class: 0 OP, 1 OPIMM, 2 BRANCH, 3 AUIPC, 4 LUI, 5 JALR, 6 JAL, 7 LOAD, 8 STORE, 9 LI; others illegal
cmd_funct3  in  3  funct3 field
cmd_alt  in  1  selects funct7=0100000 (SUB/SRA/SRAI)
cmd_rd  in  5  destination register
cmd_rs1  in  5  source 1
cmd_rs2  in  5  source 2 (OP, BRANCH, STORE)
cmd_imm  in  32  full signed immediate (byte offset for BRANCH/JAL; upper value imm[31:12] for LUI/AUIPC)
inst_valid  out  1  instruction word valid
inst_ready  in  1  downstream accepts
inst_data  out  32  encoded instruction
inst_last  out  1  final word of current command
err  out  1  one-cycle pulse: illegal command consumed
err_cnt  out  ERR_CNT_W  saturating illegal count

Behaviour:
- Reset: state IDLE; inst_valid=0, inst_data=0, inst_last=0, err=0, err_cnt=0. A reset mid-LI discards the pending second word.
- Output is a single register. cmd_ready = (state==IDLE) && (!inst_valid || inst_ready). This allows full throughput of 1 word/cycle.
- Latency: accept at edge N gives inst_valid at N+1.
- inst_data and inst_last are held stable while inst_valid && !inst_ready.
- Encoding uses standard RV32I formats:
  - R: OP.
  - I: OPIMM, JALR, LOAD. For SLLI/SRLI/SRAI, imm[4:0] becomes shamt and funct7 comes from cmd_alt.
  - S: STORE.
  - B: BRANCH, using imm[12:1].
  - U: LUI, AUIPC.
  - J: JAL, using imm[20:1].
  - Opcodes: OP 0110011, OPIMM 0010011, BRANCH 1100011, AUIPC 0010111, LUI 0110111, JALR 1100111, JAL 1101111, LOAD 0000011, STORE 0100011.
- Illegal commands are consumed with no word emitted, err pulsed and err_cnt incremented (saturating at all-ones):
  - undefined cmd_op;
  - LOAD funct3 in {011,110,111};
  - STORE funct3 > 010;
  - BRANCH funct3 in {010,011};
  - JALR funct3 != 000;
  - cmd_alt=1 other than OP funct3 000/101 or OPIMM funct3 101;
  - BRANCH/JAL imm[0]=1;
  - I/S imm outside [-2048,2047];
  - B imm outside [-4096,4094];
  - J imm outside ±1 MiB.
- err is registered and asserts at N+1.
- FSM states: IDLE, LI_LO.
  - LI with imm in [-2048,2047]: emit ADDI rd,x0,imm with inst_last=1; stay IDLE.
  - Other LI: emit LUI rd,(imm[31:12]+imm[11]) with inst_last=0; go to LI_LO.
  - LI_LO: when the output slot is free, load ADDI rd,rd,imm[11:0] with inst_last=1; go to IDLE.
  - The LUI is always followed by the ADDI, even when imm[11:0]=0.
  - cmd_ready=0 in LI_LO.
- All non-LI words have inst_last=1.
- rd=x0 is legal and encoded as given.

Optional Feature:
INST_ENC_LI_EN:
- Defined: cmd_op 9 (LI) is supported as above, with the LI_LO state.
- Undefined: LI_LO state and logic are omitted; cmd_op 9 is illegal (err pulse, counted).

Test Plan:
- ADDI x1,x0,5 (op1,f3 0,imm 5), inst_ready=1 -> inst_data 0x00500093, inst_last=1, one cycle after accept.
- SUB x3,x1,x2 (op0,alt 1); then BEQ x0,x0,+8 (op2,imm 8) back-to-back -> 0x402081B3 then 0x00000463 on consecutive cycles, cmd_ready held 1.
- LI x5,0x12345678 with inst_ready low 3 cycles -> 0x123452B7 (last 0) held stable, then 0x67828293 (last 1); cmd_ready=0 until the second word is accepted.
- LI x1,0x00000800 -> 0x000010B7 then 0x80008093. LI x1,-1 -> single 0xFFF00093.
- LOAD f3=011; BRANCH imm=3; ADDI imm=2048; op 12 -> no inst_valid, err pulses 4×, err_cnt=4. Also: ERR_CNT_W=2 saturates at 3.
- Assert reset while in LI_LO -> inst_valid=0 immediately, err_cnt=0. After release, next ADDI encodes correctly with no stale ADDI from LI.
